// File: rtl/framebuffer_arbiter_pkg.sv
// Display-mode constants shared by the display path blocks, plus the arbiter FSM state type.
package framebuffer_arbiter_pkg;

    localparam int unsigned DispHRes  = 640;
    localparam int unsigned DispVRes  = 480;
    localparam int unsigned DispAddrW = $clog2(DispHRes * DispVRes);
    localparam int unsigned DispDataW = 12;
    localparam int unsigned DispLbAw  = $clog2(DispHRes);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain
    } fb_state_e;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Bus bundle between the arbiter, the display timing path, the drawing client and the RAMs.
interface framebuffer_arbiter_if
    import framebuffer_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DispAddrW,
    parameter int unsigned DATA_W = DispDataW,
    parameter int unsigned LB_AW  = DispLbAw
);
    logic              i_frame;
    logic              i_line_req;
    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_lb_we;
    logic [LB_AW:0]    o_lb_addr;
    logic [DATA_W-1:0] o_lb_data;
    logic              o_busy;
    logic              o_overrun;

    // Arbiter side.
    modport master (
        input  i_frame, i_line_req, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_lb_we, o_lb_addr, o_lb_data, o_busy, o_overrun
    );

    // Environment side: timing path, drawing client and RAMs.
    modport slave (
        output i_frame, i_line_req, i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_lb_we, o_lb_addr, o_lb_data, o_busy, o_overrun
    );

endinterface

// File: rtl/framebuffer_arbiter_fetch_counter.sv
// Line base / bank / read-counter sequencing and the one-cycle line-buffer write delay stage.
module framebuffer_arbiter_fetch_counter
    import framebuffer_arbiter_pkg::*;
#(
    parameter int unsigned H_RES  = DispHRes,
    parameter int unsigned ADDR_W = DispAddrW,
    parameter int unsigned LB_AW  = DispLbAw
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              frame_i,
    input  logic              start_i,
    input  logic              fetching_i,
    input  logic              drain_i,
    input  logic              drop_i,
    output logic              last_o,
    output logic [ADDR_W-1:0] start_addr_o,
    output logic              lb_we_o,
    output logic [LB_AW:0]    lb_addr_o
);
    localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(H_RES);
    localparam logic [LB_AW-1:0]  XLast    = LB_AW'(H_RES - 1);

    logic [ADDR_W-1:0] base_q, base_d;
    logic              bank_q, bank_d;
    logic              fbank_q, fbank_d;
    logic [LB_AW-1:0]  x_q, x_d;
    logic              lb_we_q;
    logic [LB_AW:0]    lb_addr_q;

    assign last_o       = (x_q == XLast);
    assign start_addr_o = frame_i ? '0 : base_q;
    assign lb_we_o      = lb_we_q;
    assign lb_addr_o    = lb_addr_q;

    always_comb begin
        base_d  = base_q;
        bank_d  = frame_i ? 1'b0 : bank_q;
        fbank_d = fbank_q;
        x_d     = x_q;
        // Frame start overrides any pending advance; a dropped request still steps the base.
        if (frame_i) begin
            base_d = '0;
        end else begin
            if (drain_i) base_d = base_d + LineStep;
            if (drop_i)  base_d = base_d + LineStep;
        end
        if (start_i) begin
            fbank_d = bank_d;
            bank_d  = ~bank_d;
            x_d     = '0;
        end else if (fetching_i && !last_o) begin
            x_d = x_q + LB_AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q    <= '0;
            bank_q    <= 1'b0;
            fbank_q   <= 1'b0;
            x_q       <= '0;
            lb_we_q   <= 1'b0;
            lb_addr_q <= '0;
        end else begin
            base_q    <= base_d;
            bank_q    <= bank_d;
            fbank_q   <= fbank_d;
            x_q       <= x_d;
            lb_we_q   <= fetching_i;
            lb_addr_q <= {fbank_q, x_q};
        end
    end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the single-port framebuffer RAM between line fetches into the line buffer and
// drawing-client writes; fetches have strict priority.
module framebuffer_arbiter
    import framebuffer_arbiter_pkg::*;
#(
    parameter int unsigned H_RES  = DispHRes,
    parameter int unsigned V_RES  = DispVRes,
    parameter int unsigned ADDR_W = DispAddrW,
    parameter int unsigned DATA_W = DispDataW,
    parameter int unsigned LB_AW  = DispLbAw
) (
    input logic                   i_pixclk,
    input logic                   i_rst_n,
    framebuffer_arbiter_if.master bus
);
    if ((64'd1 << ADDR_W) < (64'(H_RES) * 64'(V_RES))) begin : g_addr_w_check
        $error("ADDR_W too small for H_RES*V_RES");
    end
    if ((64'd1 << LB_AW) < 64'(H_RES)) begin : g_lb_aw_check
        $error("LB_AW too small for H_RES");
    end

    fb_state_e         state_q;
    logic              mem_en_q, mem_we_q, busy_q, overrun_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              wr_ready, start, fetching, drain, drop, last;
    logic [ADDR_W-1:0] start_addr;

    assign wr_ready = (state_q == StIdle) && !bus.i_line_req && i_rst_n;
    assign start    = (state_q == StIdle) && bus.i_line_req;
    assign fetching = (state_q == StFetch);
    assign drain    = fetching && last;
    assign drop     = (state_q != StIdle) && bus.i_line_req;

    framebuffer_arbiter_fetch_counter #(
        .H_RES (H_RES),
        .ADDR_W(ADDR_W),
        .LB_AW (LB_AW)
    ) u_fetch_counter (
        .clk_i       (i_pixclk),
        .rst_ni      (i_rst_n),
        .frame_i     (bus.i_frame),
        .start_i     (start),
        .fetching_i  (fetching),
        .drain_i     (drain),
        .drop_i      (drop),
        .last_o      (last),
        .start_addr_o(start_addr),
        .lb_we_o     (bus.o_lb_we),
        .lb_addr_o   (bus.o_lb_addr)
    );

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if (drop) overrun_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (bus.i_line_req) begin
                        state_q    <= StFetch;
                        busy_q     <= 1'b1;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= start_addr;
                    end else if (bus.i_wr_valid) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.i_wr_addr;
                        mem_wdata_q <= bus.i_wr_data;
                    end
                end
                StFetch: begin
                    if (last) begin
                        state_q <= StDrain;
                    end else begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_wr_ready  = wr_ready;
    assign bus.o_mem_en    = mem_en_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    // Held at zero during reset so every output reads 0 while reset is asserted.
    assign bus.o_lb_data   = i_rst_n ? bus.i_mem_rdata : '0;
    assign bus.o_busy      = busy_q;
    assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with H_RES=8, ADDR_W=8, LB_AW=3 and a synchronous RAM model.
module tb_framebuffer_arbiter;
    localparam int unsigned HRes  = 8;
    localparam int unsigned VRes  = 32;
    localparam int unsigned AddrW = 8;
    localparam int unsigned DataW = 12;
    localparam int unsigned LbAw  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    framebuffer_arbiter_if #(.ADDR_W(AddrW), .DATA_W(DataW), .LB_AW(LbAw)) bus ();

    framebuffer_arbiter #(
        .H_RES (HRes),
        .V_RES (VRes),
        .ADDR_W(AddrW),
        .DATA_W(DataW),
        .LB_AW (LbAw)
    ) dut (
        .i_pixclk(clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [DataW-1:0] ram [256];
    logic [DataW-1:0] ram_q;

    function automatic logic [DataW-1:0] pat(input int a);
        return DataW'(a * 37 + 11);
    endfunction

    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
            else              ram_q <= ram[bus.o_mem_addr];
        end
    end
    assign bus.i_mem_rdata = ram_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input int addr, input int data);
        check({tag, ".en"}, 32'(bus.o_mem_en), 1);
        check({tag, ".we"}, 32'(bus.o_mem_we), 1);
        check({tag, ".addr"}, 32'(bus.o_mem_addr), addr);
        check({tag, ".wdata"}, 32'(bus.o_mem_wdata), data);
    endtask

    // Issues a line request in the current cycle and checks the whole fetch cycle by cycle.
    // ovr_at >= 0 raises a second request in that fetch cycle.
    task automatic run_fetch(input string tag, input int base, input int bank, input bit frame,
                             input int ovr_at);
        bus.i_line_req = 1'b1;
        bus.i_frame    = frame;
        #1;
        check({tag, ".ready_req"}, 32'(bus.o_wr_ready), 0);
        tick();
        bus.i_frame = 1'b0;
        for (int j = 0; j <= int'(HRes); j++) begin
            bus.i_line_req = (j == ovr_at);
            #1;
            check($sformatf("%s.busy%0d", tag, j), 32'(bus.o_busy), 1);
            check($sformatf("%s.ready%0d", tag, j), 32'(bus.o_wr_ready), 0);
            if (j < int'(HRes)) begin
                check($sformatf("%s.en%0d", tag, j), 32'(bus.o_mem_en), 1);
                check($sformatf("%s.we%0d", tag, j), 32'(bus.o_mem_we), 0);
                check($sformatf("%s.addr%0d", tag, j), 32'(bus.o_mem_addr), (base + j) % 256);
            end else begin
                check($sformatf("%s.en_drain", tag), 32'(bus.o_mem_en), 0);
            end
            if (j > 0) begin
                check($sformatf("%s.lbwe%0d", tag, j), 32'(bus.o_lb_we), 1);
                check($sformatf("%s.lbaddr%0d", tag, j), 32'(bus.o_lb_addr),
                      bank * int'(HRes) + j - 1);
                check($sformatf("%s.lbdata%0d", tag, j), 32'(bus.o_lb_data),
                      32'(pat((base + j - 1) % 256)));
            end else begin
                check($sformatf("%s.lbwe0", tag), 32'(bus.o_lb_we), 0);
            end
            tick();
        end
        bus.i_line_req = 1'b0;
        #1;
        check({tag, ".busy_end"}, 32'(bus.o_busy), 0);
        check({tag, ".lbwe_end"}, 32'(bus.o_lb_we), 0);
        check({tag, ".ready_end"}, 32'(bus.o_wr_ready), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".en"}, 32'(bus.o_mem_en), 0);
        check({tag, ".we"}, 32'(bus.o_mem_we), 0);
        check({tag, ".addr"}, 32'(bus.o_mem_addr), 0);
        check({tag, ".wdata"}, 32'(bus.o_mem_wdata), 0);
        check({tag, ".lbwe"}, 32'(bus.o_lb_we), 0);
        check({tag, ".lbaddr"}, 32'(bus.o_lb_addr), 0);
        check({tag, ".lbdata"}, 32'(bus.o_lb_data), 0);
        check({tag, ".busy"}, 32'(bus.o_busy), 0);
        check({tag, ".ovr"}, 32'(bus.o_overrun), 0);
        check({tag, ".ready"}, 32'(bus.o_wr_ready), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = pat(i);
        ram_q          = '0;
        bus.i_frame    = 1'b0;
        bus.i_line_req = 1'b0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;

        // Reset: outputs low, ready low even with a pending write.
        repeat (2) tick();
        check_all_zero("rst");
        bus.i_wr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst.ready_after", 32'(bus.o_wr_ready), 1);
        tick();

        // Frame, then three lines: bank alternates, base advances by 8.
        bus.i_frame = 1'b1;
        tick();
        bus.i_frame = 1'b0;
        check("frame.busy", 32'(bus.o_busy), 0);
        run_fetch("f0", 0, 0, 1'b0, -1);
        run_fetch("f1", 8, 1, 1'b0, -1);
        run_fetch("f2", 16, 0, 1'b0, -1);

        // Frame together with request: fetch restarts at 0 into bank 0.
        run_fetch("frm", 0, 0, 1'b1, -1);

        // Write arbitration; line request arrives while write 101 is on the bus.
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = 8'd100;
        bus.i_wr_data  = 12'h5a1;
        #1;
        check("wr.ready100", 32'(bus.o_wr_ready), 1);
        tick();
        check_write("wr100", 100, 'h5a1);
        bus.i_wr_addr = 8'd101;
        bus.i_wr_data = 12'h5a2;
        #1;
        check("wr.ready101", 32'(bus.o_wr_ready), 1);
        tick();
        check_write("wr101", 101, 'h5a2);
        bus.i_wr_addr = 8'd102;
        bus.i_wr_data = 12'h5a3;
        run_fetch("wf", 8, 1, 1'b0, -1);
        tick();
        check_write("wr102", 102, 'h5a3);
        bus.i_wr_addr = 8'd103;
        bus.i_wr_data = 12'h5a4;
        tick();
        check_write("wr103", 103, 'h5a4);
        bus.i_wr_valid = 1'b0;
        tick();
        check("wr.idle_en", 32'(bus.o_mem_en), 0);
        check("ram100", 32'(ram[100]), 'h5a1);
        check("ram101", 32'(ram[101]), 'h5a2);
        check("ram102", 32'(ram[102]), 'h5a3);
        check("ram103", 32'(ram[103]), 'h5a4);

        // Overrun: second request 3 cycles in is dropped but still steps the base.
        check("ovr.before", 32'(bus.o_overrun), 0);
        bus.i_frame = 1'b1;
        tick();
        bus.i_frame = 1'b0;
        run_fetch("ov", 0, 0, 1'b0, 2);
        check("ovr.set", 32'(bus.o_overrun), 1);
        run_fetch("ov2", 16, 1, 1'b0, -1);
        check("ovr.sticky", 32'(bus.o_overrun), 1);

        // Asynchronous reset at x=4 of a fetch from base 24.
        bus.i_line_req = 1'b1;
        tick();
        bus.i_line_req = 1'b0;
        repeat (4) tick();
        check("arst.addr_x4", 32'(bus.o_mem_addr), 28);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        tick();
        rst_n = 1'b1;
        #1;
        check("arst.ready", 32'(bus.o_wr_ready), 1);
        run_fetch("arf", 0, 0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares one single-port synchronous framebuffer RAM between the display line fetcher and a drawing client. At each line request from the display timing path, it burst-reads one line of pixels into a double-banked line buffer. Between fetches it grants the RAM to the drawing client through a valid/ready write handshake. It runs entirely in the pixel clock domain, between `display_timings` and the framebuffer/line-buffer RAMs.

## Interface
**Parameters**
- `H_RES`, 640: pixels per line, and words fetched per line request.
- `V_RES`, 480: lines per frame. Used only to size `ADDR_W`.
- `ADDR_W`, 19: framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES.
- `DATA_W`, 12: pixel word width (RGB444).
- `LB_AW`, 10: line-buffer address width per bank; must satisfy 2^LB_AW ≥ H_RES.

**Ports**
- `i_pixclk`, in, 1: pixel clock; the only clock.
- `i_rst_n`, in, 1: reset, asynchronous and active-low.
- `i_frame`, in, 1: one-cycle pulse at frame start.
- `i_line_req`, in, 1: one-cycle pulse requesting a fetch of the next line.
- `i_wr_valid`, in, 1: drawing client write request.
- `i_wr_addr`, in, ADDR_W: drawing client write address.
- `i_wr_data`, in, DATA_W: drawing client write data.
- `o_wr_ready`, out, 1: drawing client write accepted when high together with `i_wr_valid`.
- `o_mem_en`, out, 1: framebuffer RAM enable.
- `o_mem_we`, out, 1: framebuffer RAM write enable.
- `o_mem_addr`, out, ADDR_W: framebuffer RAM address.
- `o_mem_wdata`, out, DATA_W: framebuffer RAM write data.
- `i_mem_rdata`, in, DATA_W: framebuffer RAM read data; valid 1 cycle after a read.
- `o_lb_we`, out, 1: line-buffer write enable.
- `o_lb_addr`, out, LB_AW+1: line-buffer address; MSB is the bank.
- `o_lb_data`, out, DATA_W: line-buffer write data.
- `o_busy`, out, 1: high while a fetch is in progress.
- `o_overrun`, out, 1: sticky flag; a line request arrived while a fetch was still in progress.

## Operation
**State machine:** IDLE, FETCH, DRAIN.
- **IDLE → FETCH** when `i_line_req`=1.
- **FETCH → DRAIN** after the read at x = H_RES-1 is issued.
- **DRAIN → IDLE** after one cycle.

**Registers**
- `base` (ADDR_W): start address of the next line to fetch.
- `bank` (1 bit): line-buffer bank the next fetch fills.
- `x` (LB_AW): read counter.

**Fetch**
- On leaving IDLE for FETCH:
  - latch `fbank` = `bank`, then toggle `bank`;
  - clear `x`.
- In FETCH, one read per cycle: `o_mem_en`=1, `o_mem_we`=0, `o_mem_addr`=`base`+`x`.
- On entering DRAIN, `base` += H_RES. Addition is modulo 2^ADDR_W.

**Line-buffer write**
- `o_lb_we` and `o_lb_addr` = {`fbank`, `x`} are the read-issue signals delayed by one register stage.
- `o_lb_data` = `i_mem_rdata`, passed through combinationally.

**Drawing writes**
- `o_wr_ready` = (state==IDLE) && !`i_line_req` && `i_rst_n`. It is combinational, and fetch has strict priority.
- An accepted write drives `o_mem_en`=1, `o_mem_we`=1, `o_mem_addr`=`i_wr_addr`, `o_mem_wdata`=`i_wr_data` for exactly one cycle.

**Frame start:** `i_frame` sets `base`=0 and `bank`=0. It does not abort a fetch in progress.

**Overrun**
- `i_line_req` in FETCH or DRAIN sets `o_overrun`=1; only reset clears it.
- The request is otherwise dropped, except that `base` still advances by H_RES so later lines stay aligned.
- `bank` does not toggle on a dropped request.

## Timing
- **Reset:** every output is 0 (`o_wr_ready` included), state=IDLE, `base`=0, `bank`=0, `overrun`=0. Reset mid-fetch abandons the fetch immediately.
- **Memory-port outputs** are registered. A request sampled at clock edge k is driven on the port from edge k.
- **Line request** at edge E0:
  - reads are issued in cycles E0 … E0+H_RES-1;
  - line-buffer writes occur in cycles E0+1 … E0+H_RES;
  - `o_busy` is high from E0 through the DRAIN cycle, H_RES+1 cycles in total;
  - `o_wr_ready` returns to 1 at E0+H_RES+1.
- **Write** accepted at edge k: the RAM write occurs in cycle k (one cycle of `o_mem_we`). Back-to-back writes sustain 1 per cycle.
- **Simultaneous events**
  - `i_line_req` + `i_wr_valid` in IDLE: the fetch wins and the write is held, because `o_wr_ready`=0.
  - `i_frame` + `i_line_req` together: the frame update is applied first, so the fetch reads from address 0 into bank 0.

## Structure
- State encodings are localparams inside the block.
- The shared display package/header holds the per-mode constants (H_RES, V_RES, and ADDR_W derivation), so this block and `display_timings` get them from one place.
- Optional sub-module: `fetch_counter`, which handles `x`/`base` sequencing and the `lb_we` delay stage.
- The line-buffer RAM itself stays external.

## Test plan
All scenarios use H_RES=8, ADDR_W=8, LB_AW=3.
- **Basic fetch:** `i_frame` then `i_line_req`.
  - Expect reads at addresses 0–7 on consecutive cycles.
  - Expect `o_lb_addr` 8–15? No: bank 0 gives `o_lb_addr` 0–7, one cycle later, with data matching the RAM model.
  - Expect `o_busy` high for 9 cycles.
- **Bank and base advance:** a second `i_line_req`.
  - Expect reads at addresses 8–15 and `o_lb_addr` 8–15 (bank 1).
  - A third request returns to bank 0 with reads at 16–23.
- **Write arbitration:** `i_wr_valid` held high with addresses 100–103, and `i_line_req` asserted during the second accepted write.
  - Expect writes 100 and 101 to complete.
  - Expect `o_wr_ready` low for 9 cycles, then writes 102 and 103 to complete afterwards with no data lost.
- **Overrun:** `i_line_req` issued 3 cycles after a prior request.
  - Expect `o_overrun`=1 sticky and the current fetch unaffected.
  - The next accepted fetch starts at address 16 with bank 1.
- **Frame reset:** `i_frame` together with `i_line_req` after two lines.
  - Expect reads at addresses 0–7 into bank 0.
- **Async reset mid-fetch:** drop `i_rst_n` at x=4.
  - Expect all outputs 0 immediately.
  - After release, `o_wr_ready`=1 and the next fetch starts at address 0.
